safety_island_axi_isolate: RTL and testbench
============================================

# safety_island_axi_isolate

AXI4 isolation stage that sits directly downstream of the external-input CDC destination and in front of the safety island's internal crossbar. It drives the `axi_isolate_i` / `axi_isolated_o` pair of the island.

On an isolate request it does three things:
- stops accepting new bursts;
- drains every burst already in flight;
- then reports a clean, quiescent boundary.

This lets the host detach the island, or reconfigure it, without truncating transactions.

## Interface
Parameters:
- `MaxTxns`, 16: maximum outstanding bursts per counter (write-address, write-data, read). Must be ≥1.
- `axi_req_t`, logic: AXI request struct.
- `axi_rsp_t`, logic: AXI response struct.
- `CntWidth`, `$clog2(MaxTxns+1)`: derived. Do not override.

Ports:
- `clk_i`, in, 1: island clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `isolate_i`, in, 1: isolate request, level-sensitive.
- `isolated_o`, out, 1: boundary is isolated and quiescent.
- `slv_req_i`, in, `axi_req_t`: from CDC destination.
- `slv_rsp_o`, out, `axi_rsp_t`: to CDC destination.
- `mst_req_o`, out, `axi_req_t`: to internal crossbar.
- `mst_rsp_i`, in, `axi_rsp_t`: from internal crossbar.

## Operation
- **Pass-through:** all payload fields are combinational pass-through. Only `aw_valid`/`aw_ready`, `ar_valid`/`ar_ready` and `w_valid`/`w_ready` are gated. B and R always pass unmodified.
- **Counters:**
  - `aw_cnt`: +1 on mst AW handshake, −1 on mst B handshake.
  - `w_cnt`: +1 on mst AW handshake, −1 on mst W handshake with `w.last`.
  - `ar_cnt`: +1 on mst AR handshake, −1 on mst R handshake with `r.last`.
  - A simultaneous increment and decrement leaves the counter unchanged.
  - A decrement at zero is an assertion failure.
- **W gating:** W is forwarded only while `w_cnt > 0`. AW must precede or coincide with its first W beat. A slave is permitted to wait for AW, so this is legal.
- **Full:** AW is blocked (slave `aw_ready=0`, mst `aw_valid=0`) while `aw_cnt==MaxTxns` or `w_cnt==MaxTxns`. AR is blocked while `ar_cnt==MaxTxns`.
- **Hold flags:** `aw_hold` / `ar_hold` are set when mst valid=1 and ready=0, and cleared on handshake. While a hold flag is set, the corresponding channel is forwarded regardless of state, so valid never drops mid-handshake.
- **FSM states** (encoding in package): `ST_NORMAL`, `ST_DRAIN`, `ST_ISOLATED`.
  - `ST_NORMAL` → `ST_DRAIN` when `isolate_i=1`.
  - `ST_DRAIN`: new AW/AR are blocked unless a hold flag is set; W/B/R keep flowing.
    - → `ST_ISOLATED` when all counters are 0 and both hold flags are 0.
    - → `ST_NORMAL` if `isolate_i=0`.
  - `ST_ISOLATED`: AW/AR/W blocked. Leaves to `ST_NORMAL` when `isolate_i=0`.
- `isolated_o` = registered (`state==ST_ISOLATED`).

## Timing
- **Reset values:** state `ST_NORMAL`; all counters 0; hold flags 0; `isolated_o` 0. All mst valids are 0 because the slave valids are 0 in reset.
- **Zero-latency datapath:** no pipeline registers on any channel.
- **Isolate latency on an idle bus:** `isolate_i` sampled high at edge k gives `ST_DRAIN` after k, `ST_ISOLATED` after k+1, and `isolated_o=1` after k+2.
- **Isolate latency with traffic:** `isolated_o` rises 2 cycles after the last B or last-R handshake that brings all counters to 0.
- **Release:** `isolate_i` low at edge k gives `ST_NORMAL` after k. `isolated_o` falls after k+1. AW/AR are accepted from cycle k+1.
- **Reset mid-burst:** all state is cleared asynchronously. The fabric is reset with the island, so no recovery of in-flight bursts is attempted.

## Structure
- `safety_island_pkg` gets the `axi_iso_state_e` enum.
- Sub-module `safety_island_txn_counter`:
  - inc/dec counter of width `CntWidth`;
  - outputs `zero_o` and `full_o`;
  - asserts on underflow;
  - instantiated 3×.
- The top contains the FSM, the hold flags and the gating logic.

## Test plan
- **Idle isolate:** with no traffic, raise `isolate_i` at cycle 0 → `isolated_o=1` from cycle 2; an AW presented in cycle 3 sees `aw_ready=0` and nothing appears on mst.
- **Write drain:** issue a 4-beat write, then raise `isolate_i` after the AW handshake but before any W beat → all 4 W beats and the B pass; `isolated_o` rises 2 cycles after the B handshake.
- **Read drain plus new request:** issue an 8-beat read, raise isolate, then present a new AR → the new AR is stalled; `isolated_o` rises 2 cycles after the last R; dropping `isolate_i` lets the stalled AR handshake within 1 cycle.
- **Held AW:** hold mst `aw_ready=0` while AW is valid, then raise isolate → mst `aw_valid` stays 1 until the handshake, and the burst completes before `isolated_o`.
- **Full counter:** with `MaxTxns=2`, issue 3 ARs and withhold R → the third AR stalls until the first last-R, then is accepted in the same cycle.
- **Reset mid-drain:** pull `rst_ni` low while in `ST_DRAIN` with `aw_cnt=3` → `isolated_o=0` and all counters are 0 immediately.

Source files
------------

// File: rtl/safety_island_pkg.sv
// rtl/safety_island_pkg.sv - shared types for the safety island AXI isolation stage
//
// Contents:
//   axi_iso_state_e : isolation FSM encoding
//   *_chan_t        : AXI4 channel payloads used by the default request/response structs
//   axi_iso_req_t   : default AXI request struct (AW, W, AR payload + valids, B/R readies)
//   axi_iso_rsp_t   : default AXI response struct (AW/W/AR readies, B, R payload + valids)

package safety_island_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_ISOLATED = 2'd2
  } axi_iso_state_e;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ax_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_iso_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } axi_iso_rsp_t;

endpackage

// File: rtl/safety_island_txn_counter.sv
// rtl/safety_island_txn_counter.sv - outstanding-burst up/down counter
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   inc_i         : one burst opened this cycle
//   dec_i         : one burst closed this cycle
//   zero_o        : no bursts outstanding
//   full_o        : MaxTxns bursts outstanding

module safety_island_txn_counter #(
  parameter int unsigned MaxTxns  = 16,
  parameter int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o,
  output logic full_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign full_o = (cnt_q == CntWidth'(MaxTxns));

  // A close with nothing open means the fabric broke protocol.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(dec_i && zero_o));
  // The top gates opens on full, so an open at full is a gating bug.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(inc_i && !dec_i && full_o));

endmodule

// File: rtl/safety_island_axi_isolate.sv
// rtl/safety_island_axi_isolate.sv - AXI4 isolation stage with burst drain for the safety island
//
// Ports:
//   clk_i, rst_ni : island clock, asynchronous active-low reset
//   isolate_i     : level-sensitive isolate request
//   isolated_o    : boundary is isolated and quiescent (registered)
//   slv_req_i/o   : AXI request in / response out, towards the CDC destination
//   mst_req_o/i   : AXI request out / response in, towards the internal crossbar

module safety_island_axi_isolate
  import safety_island_pkg::*;
#(
  parameter int unsigned MaxTxns   = 16,
  parameter type         axi_req_t = safety_island_pkg::axi_iso_req_t,
  parameter type         axi_rsp_t = safety_island_pkg::axi_iso_rsp_t,
  parameter int unsigned CntWidth  = $clog2(MaxTxns + 1)
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     isolate_i,
  output logic     isolated_o,
  input  axi_req_t slv_req_i,
  output axi_rsp_t slv_rsp_o,
  output axi_req_t mst_req_o,
  input  axi_rsp_t mst_rsp_i
);

  axi_iso_state_e state_q, state_d;
  logic aw_hold_q, aw_hold_d;
  logic ar_hold_q, ar_hold_d;
  logic isolated_q, isolated_d;

  logic aw_zero, aw_full, w_zero, w_full, ar_zero, ar_full;
  logic aw_room, ar_room;
  logic aw_fwd, ar_fwd, w_fwd;
  logic mst_aw_valid, mst_ar_valid;
  logic mst_aw_hs, mst_ar_hs, mst_b_hs, mst_w_last_hs, mst_r_last_hs;

  // Handshakes are derived from inputs and gate terms only, so no output
  // struct is read back into its own logic.
  assign mst_aw_valid  = slv_req_i.aw_valid & aw_fwd;
  assign mst_ar_valid  = slv_req_i.ar_valid & ar_fwd;
  assign mst_aw_hs     = mst_aw_valid & mst_rsp_i.aw_ready;
  assign mst_ar_hs     = mst_ar_valid & mst_rsp_i.ar_ready;
  assign mst_b_hs      = mst_rsp_i.b_valid & slv_req_i.b_ready;
  assign mst_w_last_hs = slv_req_i.w_valid & w_fwd & mst_rsp_i.w_ready & slv_req_i.w.last;
  assign mst_r_last_hs = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;

  // A close in the same cycle frees a slot, so a burst waiting on full is
  // taken in the very cycle the oldest one completes.
  assign aw_room = (!aw_full || mst_b_hs) && (!w_full || mst_w_last_hs);
  assign ar_room = !ar_full || mst_r_last_hs;

  // Hold flags override state so a presented valid never drops mid-handshake.
  assign aw_fwd = aw_hold_q || ((state_q == ST_NORMAL) && aw_room);
  assign ar_fwd = ar_hold_q || ((state_q == ST_NORMAL) && ar_room);
  // W only follows an accepted AW; a slave may legally wait for AW first.
  assign w_fwd  = (state_q != ST_ISOLATED) && !w_zero;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = mst_aw_valid;
    mst_req_o.ar_valid = mst_ar_valid;
    mst_req_o.w_valid  = slv_req_i.w_valid & w_fwd;

    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_fwd;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_fwd;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready & w_fwd;
  end

  always_comb begin
    aw_hold_d = aw_hold_q;
    if (mst_aw_hs) begin
      aw_hold_d = 1'b0;
    end else if (mst_aw_valid) begin
      aw_hold_d = 1'b1;
    end

    ar_hold_d = ar_hold_q;
    if (mst_ar_hs) begin
      ar_hold_d = 1'b0;
    end else if (mst_ar_valid) begin
      ar_hold_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (isolate_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!isolate_i) begin
          state_d = ST_NORMAL;
        end else if (aw_zero && w_zero && ar_zero && !aw_hold_q && !ar_hold_q) begin
          state_d = ST_ISOLATED;
        end
      end
      ST_ISOLATED: begin
        if (!isolate_i) state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
    isolated_d = (state_q == ST_ISOLATED);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_NORMAL;
      aw_hold_q  <= 1'b0;
      ar_hold_q  <= 1'b0;
      isolated_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_hold_q  <= aw_hold_d;
      ar_hold_q  <= ar_hold_d;
      isolated_q <= isolated_d;
    end
  end

  assign isolated_o = isolated_q;

  safety_island_txn_counter #(.MaxTxns(MaxTxns), .CntWidth(CntWidth)) u_aw_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (mst_aw_hs),
    .dec_i  (mst_b_hs),
    .zero_o (aw_zero),
    .full_o (aw_full)
  );

  safety_island_txn_counter #(.MaxTxns(MaxTxns), .CntWidth(CntWidth)) u_w_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (mst_aw_hs),
    .dec_i  (mst_w_last_hs),
    .zero_o (w_zero),
    .full_o (w_full)
  );

  safety_island_txn_counter #(.MaxTxns(MaxTxns), .CntWidth(CntWidth)) u_ar_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (mst_ar_hs),
    .dec_i  (mst_r_last_hs),
    .zero_o (ar_zero),
    .full_o (ar_full)
  );

endmodule

// File: tb/tb_safety_island_axi_isolate.sv
// tb/tb_safety_island_axi_isolate.sv - scoreboard bench for the AXI isolation stage

module tb_safety_island_axi_isolate;
  import safety_island_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic isolate, isolated, isolate2, isolated2;
  axi_iso_req_t slv_req, mst_req, slv_req2, mst_req2;
  axi_iso_rsp_t slv_rsp, mst_rsp, slv_rsp2, mst_rsp2;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];
  logic [31:0] exp_ar[$];
  logic [31:0] exp_r[$];
  logic [31:0] exp_b[$];
  logic [31:0] exp_ar2[$];

  always #5 clk = ~clk;

  safety_island_axi_isolate #(
    .MaxTxns(16), .axi_req_t(axi_iso_req_t), .axi_rsp_t(axi_iso_rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .isolate_i(isolate), .isolated_o(isolated),
    .slv_req_i(slv_req), .slv_rsp_o(slv_rsp), .mst_req_o(mst_req), .mst_rsp_i(mst_rsp)
  );

  safety_island_axi_isolate #(
    .MaxTxns(2), .axi_req_t(axi_iso_req_t), .axi_rsp_t(axi_iso_rsp_t)
  ) dut_full (
    .clk_i(clk), .rst_ni(rst_n), .isolate_i(isolate2), .isolated_o(isolated2),
    .slv_req_i(slv_req2), .slv_rsp_o(slv_rsp2), .mst_req_o(mst_req2), .mst_rsp_i(mst_rsp2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got handshake with %0h expected none", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake the DUT presents must match the next expected item.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mst_req.aw_valid && mst_rsp.aw_ready) begin
        if (exp_aw.size() == 0) unexpected("mst_aw", mst_req.aw.addr);
        else check("mst_aw_addr", mst_req.aw.addr, exp_aw.pop_front());
      end
      if (mst_req.w_valid && mst_rsp.w_ready) begin
        if (exp_w.size() == 0) unexpected("mst_w", mst_req.w.data);
        else check("mst_w_data", mst_req.w.data, exp_w.pop_front());
      end
      if (mst_req.ar_valid && mst_rsp.ar_ready) begin
        if (exp_ar.size() == 0) unexpected("mst_ar", mst_req.ar.addr);
        else check("mst_ar_addr", mst_req.ar.addr, exp_ar.pop_front());
      end
      if (slv_rsp.b_valid && slv_req.b_ready) begin
        if (exp_b.size() == 0) unexpected("slv_b", 32'(slv_rsp.b.id));
        else check("slv_b", 32'({slv_rsp.b.id, slv_rsp.b.resp}), exp_b.pop_front());
      end
      if (slv_rsp.r_valid && slv_req.r_ready) begin
        if (exp_r.size() == 0) unexpected("slv_r", slv_rsp.r.data);
        else check("slv_r_data", slv_rsp.r.data, exp_r.pop_front());
      end
      if (mst_req2.ar_valid && mst_rsp2.ar_ready) begin
        if (exp_ar2.size() == 0) unexpected("full_mst_ar", mst_req2.ar.addr);
        else check("full_mst_ar_addr", mst_req2.ar.addr, exp_ar2.pop_front());
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    isolate  = 1'b0;
    isolate2 = 1'b0;
    slv_req  = '0;
    mst_rsp  = '0;
    slv_req2 = '0;
    mst_rsp2 = '0;
    slv_req.b_ready   = 1'b1;
    slv_req.r_ready   = 1'b1;
    slv_req2.b_ready  = 1'b1;
    slv_req2.r_ready  = 1'b1;
    mst_rsp.aw_ready  = 1'b1;
    mst_rsp.w_ready   = 1'b1;
    mst_rsp.ar_ready  = 1'b1;
    mst_rsp2.aw_ready = 1'b1;
    mst_rsp2.w_ready  = 1'b1;
    mst_rsp2.ar_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_isolated", 32'(isolated), 32'd0);
    check("rst_aw_cnt", 32'(dut.u_aw_cnt.cnt_q), 32'd0);
    check("rst_w_cnt", 32'(dut.u_w_cnt.cnt_q), 32'd0);
    check("rst_ar_cnt", 32'(dut.u_ar_cnt.cnt_q), 32'd0);
    check("rst_mst_aw_valid", 32'(mst_req.aw_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Idle isolate
    isolate = 1'b1;
    tick(); check("idle_iso_k", 32'(isolated), 32'd0);
    tick(); check("idle_iso_k1", 32'(isolated), 32'd0);
    tick(); check("idle_iso_k2", 32'(isolated), 32'd1);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h1000;
    @(negedge clk);
    check("iso_slv_aw_ready", 32'(slv_rsp.aw_ready), 32'd0);
    check("iso_mst_aw_valid", 32'(mst_req.aw_valid), 32'd0);
    tick(); tick();
    slv_req.aw_valid = 1'b0;
    isolate = 1'b0;
    tick(); check("release_iso_k", 32'(isolated), 32'd1);
    tick(); check("release_iso_k1", 32'(isolated), 32'd0);

    // Write drain
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h2000;
    slv_req.aw.len   = 8'd3;
    exp_aw.push_back(32'h2000);
    tick();
    slv_req.aw_valid = 1'b0;
    isolate = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slv_req.w_valid = 1'b1;
      slv_req.w.data  = 32'hA0 + i;
      slv_req.w.last  = (i == 3);
      exp_w.push_back(32'hA0 + i);
      tick();
    end
    slv_req.w_valid = 1'b0;
    slv_req.w.last  = 1'b0;
    @(negedge clk);
    check("drain_slv_aw_ready", 32'(slv_rsp.aw_ready), 32'd0);
    check("wdrain_iso_pre_b", 32'(isolated), 32'd0);
    tick();
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 4'h5;
    mst_rsp.b.resp  = 2'b00;
    exp_b.push_back(32'h14);
    tick();
    mst_rsp.b_valid = 1'b0;
    check("wdrain_iso_b0", 32'(isolated), 32'd0);
    tick(); check("wdrain_iso_b1", 32'(isolated), 32'd0);
    tick(); check("wdrain_iso_b2", 32'(isolated), 32'd1);
    isolate = 1'b0;
    tick(); tick();

    // Read drain plus new request
    slv_req.ar_valid = 1'b1;
    slv_req.ar.addr  = 32'h3000;
    slv_req.ar.len   = 8'd7;
    exp_ar.push_back(32'h3000);
    tick();
    slv_req.ar_valid = 1'b0;
    isolate = 1'b1;
    tick();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.addr  = 32'h3100;
    slv_req.ar.len   = 8'd0;
    @(negedge clk);
    check("drain_slv_ar_ready", 32'(slv_rsp.ar_ready), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      mst_rsp.r_valid = 1'b1;
      mst_rsp.r.data  = 32'hB0 + i;
      mst_rsp.r.last  = (i == 7);
      exp_r.push_back(32'hB0 + i);
      tick();
    end
    mst_rsp.r_valid = 1'b0;
    mst_rsp.r.last  = 1'b0;
    check("rdrain_iso_r0", 32'(isolated), 32'd0);
    tick(); check("rdrain_iso_r1", 32'(isolated), 32'd0);
    tick(); check("rdrain_iso_r2", 32'(isolated), 32'd1);
    @(negedge clk);
    check("iso_slv_ar_ready", 32'(slv_rsp.ar_ready), 32'd0);
    isolate = 1'b0;
    exp_ar.push_back(32'h3100);
    tick();
    @(negedge clk);
    check("release_slv_ar_ready", 32'(slv_rsp.ar_ready), 32'd1);
    tick();
    slv_req.ar_valid = 1'b0;
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.data  = 32'hC0;
    mst_rsp.r.last  = 1'b1;
    exp_r.push_back(32'hC0);
    tick();
    mst_rsp.r_valid = 1'b0;
    mst_rsp.r.last  = 1'b0;
    tick();

    // Held AW
    mst_rsp.aw_ready = 1'b0;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h4000;
    slv_req.aw.len   = 8'd0;
    tick();
    isolate = 1'b1;
    tick();
    @(negedge clk);
    check("held_mst_aw_valid0", 32'(mst_req.aw_valid), 32'd1);
    tick();
    @(negedge clk);
    check("held_mst_aw_valid1", 32'(mst_req.aw_valid), 32'd1);
    tick();
    check("held_iso", 32'(isolated), 32'd0);
    mst_rsp.aw_ready = 1'b1;
    exp_aw.push_back(32'h4000);
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b1;
    slv_req.w.data   = 32'hD0;
    slv_req.w.last   = 1'b1;
    exp_w.push_back(32'hD0);
    tick();
    slv_req.w_valid = 1'b0;
    slv_req.w.last  = 1'b0;
    check("held_iso_pre_b", 32'(isolated), 32'd0);
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 4'h6;
    mst_rsp.b.resp  = 2'b10;
    exp_b.push_back(32'h1A);
    tick();
    mst_rsp.b_valid = 1'b0;
    check("held_iso_b0", 32'(isolated), 32'd0);
    tick(); check("held_iso_b1", 32'(isolated), 32'd0);
    tick(); check("held_iso_b2", 32'(isolated), 32'd1);
    isolate = 1'b0;
    tick(); tick();

    // Full counter (MaxTxns=2)
    slv_req2.ar_valid = 1'b1;
    slv_req2.ar.addr  = 32'h5000;
    exp_ar2.push_back(32'h5000);
    tick();
    slv_req2.ar.addr  = 32'h5001;
    exp_ar2.push_back(32'h5001);
    tick();
    slv_req2.ar.addr  = 32'h5002;
    @(negedge clk);
    check("full_slv_ar_ready", 32'(slv_rsp2.ar_ready), 32'd0);
    check("full_mst_ar_valid", 32'(mst_req2.ar_valid), 32'd0);
    tick();
    mst_rsp2.r_valid = 1'b1;
    mst_rsp2.r.last  = 1'b1;
    exp_ar2.push_back(32'h5002);
    @(negedge clk);
    check("full_same_cycle_ar_ready", 32'(slv_rsp2.ar_ready), 32'd1);
    tick();
    slv_req2.ar_valid = 1'b0;
    tick(); tick();
    mst_rsp2.r_valid = 1'b0;
    mst_rsp2.r.last  = 1'b0;
    check("full_ar_cnt_drained", 32'(dut_full.u_ar_cnt.cnt_q), 32'd0);

    // Reset mid-drain
    slv_req.aw_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slv_req.aw.addr = 32'h6000 + i;
      exp_aw.push_back(32'h6000 + i);
      tick();
    end
    slv_req.aw_valid = 1'b0;
    isolate = 1'b1;
    tick(); tick();
    check("pre_rst_aw_cnt", 32'(dut.u_aw_cnt.cnt_q), 32'd3);
    check("pre_rst_state", 32'(dut.state_q), 32'(ST_DRAIN));
    rst_n = 1'b0;
    #1;
    check("midrst_isolated", 32'(isolated), 32'd0);
    check("midrst_aw_cnt", 32'(dut.u_aw_cnt.cnt_q), 32'd0);
    check("midrst_w_cnt", 32'(dut.u_w_cnt.cnt_q), 32'd0);
    check("midrst_ar_cnt", 32'(dut.u_ar_cnt.cnt_q), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(ST_NORMAL));
    #1;
    rst_n   = 1'b1;
    isolate = 1'b0;
    tick(); tick();

    check("queues_empty",
          32'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_r.size() + exp_b.size() + exp_ar2.size()),
          32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
